// File: rtl/equilibrio_ctrl.sv
// rtl/equilibrio_ctrl.sv - balance game sequencer driving the invertible counter
module equilibrio_ctrl #(
    parameter int M           = 100,
    parameter int N           = 7,
    parameter int TICK        = 50000,
    parameter int PAUSA_TICKS = 50,
    parameter int VIDAS       = 3,
    parameter int SCORE_W     = 16
) (
    input  logic               clock,
    input  logic               zera_as_n,
    input  logic               iniciar,
    input  logic               btn_dir,
    input  logic               btn_esq,
    input  logic [N-1:0]       Q_in,
    input  logic               fim,
    input  logic               inicio,
    output logic               conta,
    output logic               count_up,
    output logic               zera_s,
    output logic [2:0]         estado,
    output logic [1:0]         vidas,
    output logic [SCORE_W-1:0] pontos,
    output logic               queda,
    output logic               game_over
);

    localparam logic [2:0] OCIOSO   = 3'd0;
    localparam logic [2:0] PREPARA  = 3'd1;
    localparam logic [2:0] JOGANDO  = 3'd2;
    localparam logic [2:0] QUEDA    = 3'd3;
    localparam logic [2:0] PAUSA    = 3'd4;
    localparam logic [2:0] FIM_JOGO = 3'd5;

    localparam int TW = (TICK > 2) ? $clog2(TICK) : 1;
    localparam int PW = $clog2(PAUSA_TICKS + 1);

    localparam logic [N-1:0]  MID        = N'(M / 2);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK - 1);
    localparam logic [PW-1:0] PAUSA_LAST = PW'(PAUSA_TICKS - 1);

    logic [2:0]    estado_r;
    logic [2:0]    estado_nx;
    logic [TW-1:0] tick_cnt;
    logic [PW-1:0] pausa_cnt;
    logic [7:0]    lfsr;
    logic          run;
    logic          tick;
    logic          caiu;
    logic          dir_cmd;

    assign estado = estado_r;
    assign run    = (estado_r == JOGANDO) || (estado_r == PAUSA);
    assign tick   = run && (tick_cnt == TICK_LAST);
    assign caiu   = fim | inicio;

    // Buttons win when exactly one is pressed; otherwise the beam drifts away from centre.
    always_comb begin
        dir_cmd = 1'b0;
        if (btn_dir && !btn_esq)
            dir_cmd = 1'b1;
        else if (btn_esq && !btn_dir)
            dir_cmd = 1'b0;
        else if (Q_in > MID)
            dir_cmd = 1'b1;
        else if (Q_in < MID)
            dir_cmd = 1'b0;
        else
            dir_cmd = lfsr[0];
    end

    assign count_up = (estado_r == JOGANDO) && dir_cmd;

    always_comb begin
        estado_nx = estado_r;
        conta     = 1'b0;
        zera_s    = 1'b0;
        queda     = 1'b0;
        game_over = 1'b0;
        case (estado_r)
            OCIOSO: begin
                if (iniciar)
                    estado_nx = PREPARA;
            end
            PREPARA: begin
                zera_s    = 1'b1;
                estado_nx = JOGANDO;
            end
            JOGANDO: begin
                // A fall suppresses the step so the counter never wraps by itself.
                if (caiu)
                    estado_nx = QUEDA;
                else if (tick)
                    conta = 1'b1;
            end
            QUEDA: begin
                zera_s    = 1'b1;
                queda     = 1'b1;
                estado_nx = (vidas == 2'd1) ? FIM_JOGO : PAUSA;
            end
            PAUSA: begin
                if (tick && (pausa_cnt == PAUSA_LAST))
                    estado_nx = JOGANDO;
            end
            FIM_JOGO: begin
                game_over = 1'b1;
                if (iniciar)
                    estado_nx = PREPARA;
            end
            default: estado_nx = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            estado_r  <= OCIOSO;
            vidas     <= 2'(VIDAS);
            pontos    <= '0;
            tick_cnt  <= '0;
            pausa_cnt <= '0;
            lfsr      <= 8'h01;
        end else begin
            estado_r <= estado_nx;
            lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

            if (!run || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 1'b1;

            case (estado_r)
                PREPARA: begin
                    vidas  <= 2'(VIDAS);
                    pontos <= '0;
                end
                JOGANDO: begin
                    if (conta && (pontos != '1))
                        pontos <= pontos + 1'b1;
                end
                QUEDA: begin
                    vidas     <= vidas - 1'b1;
                    pausa_cnt <= '0;
                end
                PAUSA: begin
                    if (tick)
                        pausa_cnt <= pausa_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/equilibrio_ctrl.md
Name: equilibrio_ctrl

Overview:
- Game-level sequencer for the balance game; drives contador_m_invertible (conta, count_up, zera_s) from player buttons plus a drift rule.
- Detects a fall when the counter hits either end, manages lives, a pause after each fall, a survival score and game-over.
- Sits between the button debouncers and the invertible counter instance; its outputs feed display/LED logic.

Parameters:
- M, 100, counter modulus; must match the counter instance (MID = M/2, MAX = M-1).
- N, 7, counter width; must match the counter instance.
- TICK, 50000, clocks per movement step (>= 2).
- PAUSA_TICKS, 50, steps of pause after a non-final fall (>= 1).
- VIDAS, 3, initial lives (1..3).
- SCORE_W, 16, score width.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- zera_as_n  in  1  asynchronous active-low reset.
- iniciar  in  1  start request, level-sampled, one-cycle pulse expected.
- btn_dir  in  1  push toward MAX (count up).
- btn_esq  in  1  push toward 0 (count down).
- Q_in  in  N  counter value from the counter instance.
- fim  in  1  counter at MAX.
- inicio  in  1  counter at 0.
- conta  out  1  step enable to the counter.
- count_up  out  1  direction to the counter, 1 = up.
- zera_s  out  1  synchronous recentre of the counter (to MID).
- estado  out  3  current FSM state code.
- vidas  out  2  remaining lives.
- pontos  out  SCORE_W  steps survived, saturating.
- queda  out  1  one-cycle fall pulse.
- game_over  out  1  high while in FIM_JOGO.

Behaviour:
- Reset (zera_as_n = 0, immediate, any state, including mid-game):
  - estado = OCIOSO, vidas = VIDAS, pontos = 0, tick counter = 0, pause counter = 0, lfsr = 8'h01.
  - conta = 0, zera_s = 0, queda = 0, game_over = 0, count_up = 0.
- State codes: OCIOSO = 0, PREPARA = 1, JOGANDO = 2, QUEDA = 3, PAUSA = 4, FIM_JOGO = 5. Unused codes go to OCIOSO.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; shifts every clock outside reset.
  - Never reaches 0.
- Tick:
  - Counter 0..TICK-1 runs in JOGANDO and PAUSA; cleared in every other state.
  - tick = 1 in the cycle where the count equals TICK-1; the counter wraps to 0 on the next edge.
- OCIOSO: outputs idle; iniciar = 1 -> PREPARA.
- PREPARA (1 cycle), then -> JOGANDO:
  - zera_s = 1.
  - Next edge: vidas <= VIDAS, pontos <= 0, tick counter <= 0.
- JOGANDO:
  - Fall (fim | inicio = 1) has priority:
    - conta = 0 in that cycle, so the counter's wrap-to-MID never happens under control.
    - Next state QUEDA.
  - Else on tick:
    - conta = 1 for exactly that cycle.
    - pontos <= pontos + 1, saturating at all ones.
  - count_up (combinational, valid every cycle):
    - btn_dir & !btn_esq -> 1.
    - btn_esq & !btn_dir -> 0.
    - Neither or both pressed -> drift: Q_in > MID -> 1; Q_in < MID -> 0; Q_in == MID -> lfsr[0].
  - iniciar is ignored.
- QUEDA (1 cycle):
  - zera_s = 1, queda = 1; vidas <= vidas - 1.
  - If vidas was 1 -> FIM_JOGO, else -> PAUSA with pause counter <= 0.
- PAUSA:
  - conta = 0; pause counter increments on tick.
  - On the tick where pause counter = PAUSA_TICKS-1 -> JOGANDO, tick counter restarts from 0.
  - Buttons and iniciar are ignored.
- FIM_JOGO:
  - game_over = 1; pontos and vidas (= 0) are held.
  - iniciar = 1 -> PREPARA.
- Output timing:
  - conta, zera_s, queda and game_over are combinational from state, tick and fall; no cycle is spent registering them.
  - The counter applies the step at the next edge, so Q_in changes one cycle after conta.
- Simultaneous events:
  - Fall and tick in the same cycle: fall wins; no step, no score increment.
  - Fall and iniciar in the same cycle: fall wins, iniciar is ignored.

Test Plan:
- Sim config: M=10, N=4 (MID=5, MAX=9), TICK=4, PAUSA_TICKS=2, VIDAS=3.
- Start: reset, then iniciar pulse -> zera_s for 1 cycle in PREPARA; estado=2 next cycle; vidas=3, pontos=0.
- Hold btn_dir from Q=5 -> conta every 4th clock with count_up=1; Q reaches 9 after 4 steps; next cycle conta=0, estado=3, queda=1, zera_s=1; Q=5 after; vidas=2; estado=4 for 8 clocks, then 2.
- No buttons with Q=6 -> drift up each tick until fim; with Q=4 -> drift down to 0; both buttons with Q=5 -> count_up equals lfsr[0].
- Three falls -> third QUEDA goes to estado=5, game_over=1, vidas=0, pontos frozen; iniciar -> PREPARA, pontos=0, vidas=3.
- Reset asserted mid-JOGANDO at Q=7 -> immediate estado=0, conta=0, pontos=0, vidas=3 while zera_as_n is low.
- Force fim=1 on a tick cycle -> conta stays 0 and pontos is unchanged; estado=3 next.
